// File: rtl/i2c_scl_phase_gen.sv
// -----------------------------------------------------------------------------
// i2c_scl_phase_gen
//
// I2C master-side SCL generator. Each SCL period is split into four quarters:
//   P0 (low)  -> P1 (low)  -> P2 (high) -> P3 (high)
// A one-cycle strobe marks the first cycle of each quarter:
//   fall_tick   : SCL pulled low (start of P0)
//   drive_tick  : mid-low point, data may change (start of P1)
//   rise_tick   : SCL released (start of P2)
//   sample_tick : mid-high point, data is sampled (start of P3)
// Every quarter lasts div_q+1 cycles. div_q is captured from div each time P0
// is entered, so a period never changes length part-way through.
// With STRETCH_EN=1, P2 first waits SYNC_STAGES settle cycles so that the
// synchronised bus SCL reflects the released line. It then holds its count
// while a slave keeps SCL low. If the hold reaches STRETCH_MAX cycles, the
// generator raises a sticky timeout and drops back to IDLE.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   en           in   run request, looked at only when a period may start
//   div          in   [DIV_W] quarter-period length minus 1
//   scl_in       in   bus SCL (asynchronous)
//   clr_timeout  in   clears the timeout flag
//   scl_out      out  SCL drive level (0 = pull low, 1 = release)
//   phase        out  [2] current quarter 0..3 (3 while idle)
//   active       out  generator running
//   fall_tick    out  strobe, SCL went 1->0
//   drive_tick   out  strobe, mid-low point
//   rise_tick    out  strobe, SCL went 0->1
//   sample_tick  out  strobe, mid-high point
//   stretching   out  a slave held SCL low during the previous cycle of P2
//   timeout      out  sticky stretch-timeout flag
// -----------------------------------------------------------------------------
module i2c_scl_phase_gen #(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_EN  = 1,
  parameter int TO_W        = 16,
  parameter int STRETCH_MAX = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             scl_in,
  input  logic             clr_timeout,
  output logic             scl_out,
  output logic [1:0]       phase,
  output logic             active,
  output logic             fall_tick,
  output logic             drive_tick,
  output logic             rise_tick,
  output logic             sample_tick,
  output logic             stretching,
  output logic             timeout
);

  localparam int SET_W = $clog2(SYNC_STAGES + 1);

  localparam logic [DIV_W-1:0] CNT_ZERO     = DIV_W'(0);
  localparam logic [DIV_W-1:0] CNT_ONE      = DIV_W'(1);
  localparam logic [SET_W-1:0] SETTLE_ZERO  = SET_W'(0);
  localparam logic [SET_W-1:0] SETTLE_ONE   = SET_W'(1);
  localparam logic [SET_W-1:0] SETTLE_LAST  = SET_W'(SYNC_STAGES);
  localparam logic [TO_W-1:0]  STRETCH_ZERO = TO_W'(0);
  localparam logic [TO_W-1:0]  STRETCH_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0]  STRETCH_LAST = TO_W'(STRETCH_MAX - 1);
  localparam bit               STRETCH_ON   = (STRETCH_EN != 0);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [DIV_W-1:0]       cnt_r;
  logic [DIV_W-1:0]       cnt_s;
  logic [DIV_W-1:0]       div_q_r;
  logic [DIV_W-1:0]       div_q_s;
  logic [SET_W-1:0]       settle_r;
  logic [SET_W-1:0]       settle_s;
  logic [TO_W-1:0]        stretch_r;
  logic [TO_W-1:0]        stretch_s;
  logic [SYNC_STAGES-1:0] sync_r;

  logic       scl_sync_s;
  logic       cnt_done_s;
  logic       fall_s;
  logic       drive_s;
  logic       rise_s;
  logic       sample_s;
  logic       stretching_s;
  logic       timeout_s;
  logic       scl_out_s;
  logic       active_s;
  logic [1:0] phase_s;

  assign scl_sync_s = sync_r[SYNC_STAGES-1];
  assign cnt_done_s = (cnt_r == div_q_r);

  // scl_in synchroniser; idles high like a released bus
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], scl_in};
    end
  end

  // next-state, counters and strobes
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    div_q_s      = div_q_r;
    settle_s     = settle_r;
    stretch_s    = stretch_r;
    fall_s       = 1'b0;
    drive_s      = 1'b0;
    rise_s       = 1'b0;
    sample_s     = 1'b0;
    stretching_s = 1'b0;
    // a new timeout below overrides a simultaneous clear
    timeout_s    = timeout & ~clr_timeout;

    case (state_r)
      IDLE: begin
        if (en && !timeout) begin
          state_s = P0;
          cnt_s   = CNT_ZERO;
          div_q_s = div;
          fall_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end

      P0: begin
        if (cnt_done_s) begin
          state_s = P1;
          cnt_s   = CNT_ZERO;
          drive_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      P1: begin
        if (cnt_done_s) begin
          state_s   = P2;
          cnt_s     = CNT_ZERO;
          settle_s  = SETTLE_ZERO;
          stretch_s = STRETCH_ZERO;
          rise_s    = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      P2: begin
        if (STRETCH_ON && (settle_r != SETTLE_LAST)) begin
          // the synchroniser still holds samples from the low phase
          settle_s = settle_r + SETTLE_ONE;
        end else if (STRETCH_ON && !scl_sync_s) begin
          if (stretch_r == STRETCH_LAST) begin
            timeout_s = 1'b1;
            state_s   = IDLE;
            cnt_s     = CNT_ZERO;
            settle_s  = SETTLE_ZERO;
            stretch_s = STRETCH_ZERO;
          end else begin
            stretch_s    = stretch_r + STRETCH_ONE;
            stretching_s = 1'b1;
          end
        end else begin
          stretch_s = STRETCH_ZERO;
          if (cnt_done_s) begin
            state_s  = P3;
            cnt_s    = CNT_ZERO;
            settle_s = SETTLE_ZERO;
            sample_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
      end

      P3: begin
        if (cnt_done_s) begin
          if (en && !timeout) begin
            state_s = P0;
            cnt_s   = CNT_ZERO;
            div_q_s = div;
            fall_s  = 1'b1;
          end else begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      default: begin
        state_s   = IDLE;
        cnt_s     = CNT_ZERO;
        settle_s  = SETTLE_ZERO;
        stretch_s = STRETCH_ZERO;
      end
    endcase
  end

  // level outputs follow the state being entered so they register in step
  always_comb begin
    phase_s   = 2'd3;
    scl_out_s = 1'b1;
    active_s  = 1'b1;
    case (state_s)
      P0: begin
        phase_s   = 2'd0;
        scl_out_s = 1'b0;
      end
      P1: begin
        phase_s   = 2'd1;
        scl_out_s = 1'b0;
      end
      P2: begin
        phase_s = 2'd2;
      end
      P3: begin
        phase_s = 2'd3;
      end
      default: begin
        active_s = 1'b0;
      end
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      div_q_r     <= CNT_ZERO;
      settle_r    <= SETTLE_ZERO;
      stretch_r   <= STRETCH_ZERO;
      scl_out     <= 1'b1;
      phase       <= 2'd3;
      active      <= 1'b0;
      fall_tick   <= 1'b0;
      drive_tick  <= 1'b0;
      rise_tick   <= 1'b0;
      sample_tick <= 1'b0;
      stretching  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      div_q_r     <= div_q_s;
      settle_r    <= settle_s;
      stretch_r   <= stretch_s;
      scl_out     <= scl_out_s;
      phase       <= phase_s;
      active      <= active_s;
      fall_tick   <= fall_s;
      drive_tick  <= drive_s;
      rise_tick   <= rise_s;
      sample_tick <= sample_s;
      stretching  <= stretching_s;
      timeout     <= timeout_s;
    end
  end

endmodule

// File: tb/tb_i2c_scl_phase_gen.sv
// -----------------------------------------------------------------------------
// Bench for i2c_scl_phase_gen. Three instances share clk/rst:
//   inst 0: STRETCH_EN=0                  (plain timing, div changes, reset)
//   inst 1: STRETCH_EN=1, STRETCH_MAX=1024 (slave stretch of 10 cycles)
//   inst 2: STRETCH_EN=1, STRETCH_MAX=8    (stretch timeout and clear)
// The bus SCL seen by each instance is the wired-AND of its own drive and a
// bench-controlled slave hold. A quarter-based model predicts every output of
// every instance each cycle; directed literal checks pin the tick spacing.
// -----------------------------------------------------------------------------
module tb_i2c_scl_phase_gen;

  localparam int SS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  en;
  logic [2:0]  slave_low;
  logic [2:0]  clr;
  logic [15:0] dv [3];

  logic [2:0] scl_o, act_o, fall_o, drive_o, rise_o, samp_o, str_o, to_o;
  logic [1:0] ph_o [3];
  logic [2:0] bus;
  assign bus = scl_o & ~slave_low;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_on   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  i2c_scl_phase_gen #(.DIV_W(16), .SYNC_STAGES(SS), .STRETCH_EN(0), .TO_W(16), .STRETCH_MAX(1024)) u_a (
    .clk(clk), .rst(rst), .en(en[0]), .div(dv[0]), .scl_in(bus[0]), .clr_timeout(clr[0]),
    .scl_out(scl_o[0]), .phase(ph_o[0]), .active(act_o[0]), .fall_tick(fall_o[0]),
    .drive_tick(drive_o[0]), .rise_tick(rise_o[0]), .sample_tick(samp_o[0]),
    .stretching(str_o[0]), .timeout(to_o[0]));

  i2c_scl_phase_gen #(.DIV_W(16), .SYNC_STAGES(SS), .STRETCH_EN(1), .TO_W(16), .STRETCH_MAX(1024)) u_b (
    .clk(clk), .rst(rst), .en(en[1]), .div(dv[1]), .scl_in(bus[1]), .clr_timeout(clr[1]),
    .scl_out(scl_o[1]), .phase(ph_o[1]), .active(act_o[1]), .fall_tick(fall_o[1]),
    .drive_tick(drive_o[1]), .rise_tick(rise_o[1]), .sample_tick(samp_o[1]),
    .stretching(str_o[1]), .timeout(to_o[1]));

  i2c_scl_phase_gen #(.DIV_W(16), .SYNC_STAGES(SS), .STRETCH_EN(1), .TO_W(4), .STRETCH_MAX(8)) u_c (
    .clk(clk), .rst(rst), .en(en[2]), .div(dv[2]), .scl_in(bus[2]), .clr_timeout(clr[2]),
    .scl_out(scl_o[2]), .phase(ph_o[2]), .active(act_o[2]), .fall_tick(fall_o[2]),
    .drive_tick(drive_o[2]), .rise_tick(rise_o[2]), .sample_tick(samp_o[2]),
    .stretching(str_o[2]), .timeout(to_o[2]));

  function automatic int se(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  function automatic int smax(input int i);
    return (i == 2) ? 8 : 1024;
  endfunction

  // ---------------- model: quarters, cycle ages and a bus history ----------------
  bit       m_run [3];
  int       m_q   [3];
  int       m_age [3];
  int       m_dq  [3];
  int       m_hi  [3];
  int       m_lo  [3];
  bit       m_to  [3];
  bit       hist  [3][64];
  logic [9:0] m_exp [3];

  // advance instance i across the coming clock edge
  task automatic model_step(input int i);
    bit f, d, r, s, st, ton, scl_e;
    int idx;
    f = 1'b0; d = 1'b0; r = 1'b0; s = 1'b0; st = 1'b0;
    if (rst) begin
      m_run[i] = 1'b0; m_q[i] = 3; m_age[i] = 0; m_dq[i] = 0;
      m_hi[i] = 0; m_lo[i] = 0; m_to[i] = 1'b0;
    end else begin
      ton = m_to[i] & ~clr[i];
      if (!m_run[i]) begin
        if (en[i] && !m_to[i]) begin
          m_run[i] = 1'b1; m_q[i] = 0; m_age[i] = 0; m_dq[i] = int'(dv[i]); f = 1'b1;
        end
      end else if (m_q[i] == 2) begin
        if (se(i) != 0) begin
          if (m_age[i] < 64) hist[i][m_age[i]] = bus[i];
          if (m_age[i] >= SS) begin
            // after the settle window the view lags the bus by SS cycles
            idx = m_age[i] - SS;
            if (idx < 64 && hist[i][idx] == 1'b0) begin
              m_lo[i]++;
              if (m_lo[i] == smax(i)) begin
                ton = 1'b1; m_run[i] = 1'b0; m_q[i] = 3;
              end else begin
                st = 1'b1;
              end
            end else begin
              m_lo[i] = 0;
              m_hi[i]++;
            end
          end
        end else begin
          m_hi[i]++;
        end
        m_age[i]++;
        if (m_run[i] && m_hi[i] == m_dq[i] + 1) begin
          m_q[i] = 3; m_age[i] = 0; s = 1'b1;
        end
      end else begin
        m_age[i]++;
        if (m_age[i] == m_dq[i] + 1) begin
          m_age[i] = 0;
          case (m_q[i])
            0: begin m_q[i] = 1; d = 1'b1; end
            1: begin m_q[i] = 2; m_hi[i] = 0; m_lo[i] = 0; r = 1'b1; end
            default: begin
              if (en[i] && !m_to[i]) begin
                m_q[i] = 0; m_dq[i] = int'(dv[i]); f = 1'b1;
              end else begin
                m_run[i] = 1'b0; m_q[i] = 3;
              end
            end
          endcase
        end
      end
      m_to[i] = ton;
    end
    scl_e = (!m_run[i]) || (m_q[i] >= 2);
    m_exp[i] = {scl_e, (m_run[i] ? 2'(m_q[i]) : 2'd3), m_run[i], f, d, r, s, st, m_to[i]};
  endtask

  function automatic logic [9:0] dut_vec(input int i);
    return {scl_o[i], ph_o[i], act_o[i], fall_o[i], drive_o[i], rise_o[i], samp_o[i], str_o[i], to_o[i]};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // per-cycle comparison against the model, then advance the model
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dut_vec(i) !== m_exp[i]) begin
          failures++;
          $display("FAIL model_inst%0d_cyc%0d: dut=%b model=%b (scl,phase,active,fall,drive,rise,sample,stretch,timeout)",
                   i, cyc, dut_vec(i), m_exp[i]);
        end
      end
    end
    for (int i = 0; i < 3; i++) model_step(i);
    if (rst) chk_on = 1'b1;
  end

  function automatic bit ev(input int i, input int kind);
    case (kind)
      0: return fall_o[i];
      1: return drive_o[i];
      2: return rise_o[i];
      3: return sample_tick_of(i);
      4: return ~act_o[i];
      default: return to_o[i];
    endcase
  endfunction

  function automatic bit sample_tick_of(input int i);
    return samp_o[i];
  endfunction

  task automatic wait_ev(input int i, input int kind, input int limit, output int t);
    t = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (ev(i, kind)) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      checks++;
      failures++;
      $display("FAIL wait_inst%0d_kind%0d: no event within %0d cycles", i, kind, limit);
    end
  endtask

  task automatic step_in();
    @(posedge clk);
    #2;
  endtask

  int k, t, t0, t1, t2, t3, r;

  initial begin
    rst = 1'b1; en = 3'b000; slave_low = 3'b000; clr = 3'b000;
    dv[0] = 16'd3; dv[1] = 16'd3; dv[2] = 16'd3;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_scl", int'(scl_o[0]), 1);
    check("reset_phase", int'(ph_o[0]), 3);
    check("reset_active", int'(act_o[0]), 0);

    // 1: div=3, period 16, ticks at +4/+8/+12/+16
    step_in(); en[0] = 1'b1; k = cyc;
    wait_ev(0, 0, 20, t0);
    check("t1_fall_latency", t0 - k, 1);
    check("t1_scl_low_at_fall", int'(scl_o[0]), 0);
    wait_ev(0, 1, 40, t); check("t1_drive", t - t0, 4);
    wait_ev(0, 2, 40, t); check("t1_rise", t - t0, 8);
    check("t1_scl_high_at_rise", int'(scl_o[0]), 1);
    wait_ev(0, 3, 40, t); check("t1_sample", t - t0, 12);
    wait_ev(0, 0, 40, t1); check("t1_period", t1 - t0, 16);

    // 3: div 3->7 in P1, en dropped in the following P2
    wait_ev(0, 1, 40, t); step_in(); dv[0] = 16'd7;
    wait_ev(0, 0, 40, t2); check("t3_period_unchanged", t2 - t1, 16);
    wait_ev(0, 2, 60, t); check("t3_rise_long", t - t2, 16);
    step_in(); en[0] = 1'b0;
    wait_ev(0, 3, 60, t); check("t3_sample_long", t - t2, 24);
    wait_ev(0, 4, 60, t); check("t3_idle_after_32", t - t2, 32);
    check("t3_idle_scl", int'(scl_o[0]), 1);

    // 2: div=0, one tick per cycle
    step_in(); dv[0] = 16'd0; en[0] = 1'b1;
    wait_ev(0, 0, 20, t3);
    check("t2_phase_at_fall", int'(ph_o[0]), 0);
    wait_ev(0, 1, 10, t); check("t2_drive", t - t3, 1);
    wait_ev(0, 2, 10, t); check("t2_rise", t - t3, 2);
    wait_ev(0, 3, 10, t); check("t2_sample", t - t3, 3);
    wait_ev(0, 0, 10, t); check("t2_period", t - t3, 4);
    step_in(); en[0] = 1'b0;
    wait_ev(0, 4, 20, t);

    // 4: slave holds SCL low for 10 cycles from the rise
    step_in(); en[1] = 1'b1;
    wait_ev(1, 1, 40, t); step_in(); slave_low[1] = 1'b1;
    wait_ev(1, 2, 40, r);
    repeat (10) step_in();
    slave_low[1] = 1'b0; en[1] = 1'b0;
    @(negedge clk); check("t4_stretching", int'(str_o[1]), 1);
    wait_ev(1, 3, 60, t); check("t4_p2_length", t - r, 16);
    check("t4_no_timeout", int'(to_o[1]), 0);
    wait_ev(1, 4, 40, t);

    // 5: permanent hold, timeout after 8 stretch cycles
    step_in(); slave_low[2] = 1'b1; en[2] = 1'b1;
    wait_ev(2, 2, 40, r);
    wait_ev(2, 5, 40, t); check("t5_timeout_time", t - r, 10);
    check("t5_idle", int'(act_o[2]), 0);
    check("t5_scl_released", int'(scl_o[2]), 1);
    repeat (5) step_in();
    @(negedge clk); check("t5_en_ignored", int'(act_o[2]), 0);
    step_in(); clr[2] = 1'b1; k = cyc;
    step_in(); clr[2] = 1'b0;
    wait_ev(2, 0, 20, t); check("t5_restart", t - k, 2);
    check("t5_cleared", int'(to_o[2]), 0);
    wait_ev(2, 5, 60, t);

    // 6: one-cycle reset during P0
    step_in(); dv[0] = 16'd3; en[0] = 1'b1;
    wait_ev(0, 0, 20, t);
    step_in(); rst = 1'b1;
    step_in(); rst = 1'b0;
    @(negedge clk);
    check("t6_scl", int'(scl_o[0]), 1);
    check("t6_phase", int'(ph_o[0]), 3);
    check("t6_ticks", int'({fall_o[0], drive_o[0], rise_o[0], samp_o[0]}), 0);
    check("t6_timeout_cleared", int'(to_o[2]), 0);
    en = 3'b000;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
